// File: rtl/matrix_result_writer.sv
// Write-side address generator for the matrix-multiply result memory.
// Takes C[i][j] in row-major order and issues one registered write per accepted element.
module matrix_result_writer #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] rows,
  input  logic [AW-1:0] cols,
  input  logic [AW-1:0] row_stride,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW-1:0] rows_q, rows_d;
  logic [AW-1:0] cols_q, cols_d;
  logic [AW-1:0] stride_q, stride_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic [AW-1:0] i_q, i_d;
  logic [AW-1:0] j_q, j_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          accept;

  assign in_ready  = (state_q == WRITE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign accept    = in_valid && (state_q == WRITE);

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    stride_d    = stride_q;
    row_base_d  = row_base_q;
    i_d         = i_q;
    j_d         = j_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          rows_d     = rows;
          cols_d     = cols;
          stride_d   = row_stride;
          row_base_d = base;
          i_d        = '0;
          j_d        = '0;
          // An empty tile still reports completion, just without any writes.
          if (rows == '0 || cols == '0) begin
            state_d = FINISH;
          end else begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = row_base_q + j_q;
          mem_wdata_d = in_data;
          if (j_q == cols_q - ONE) begin
            j_d        = '0;
            row_base_d = row_base_q + stride_q;
            i_d        = i_q + ONE;
            if (i_q == rows_q - ONE) begin
              state_d = FINISH;
            end
          end else begin
            j_d = j_q + ONE;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      stride_q    <= '0;
      row_base_q  <= '0;
      i_q         <= '0;
      j_q         <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      stride_q    <= stride_d;
      row_base_q  <= row_base_d;
      i_q         <= i_d;
      j_q         <= j_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_matrix_result_writer.sv
// Scoreboard bench for matrix_result_writer: expected {addr,data} pairs are queued
// when a tile is driven and popped by a monitor whenever mem_we is seen.
module tb_matrix_result_writer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  base;
  logic [7:0]  rows;
  logic [7:0]  cols;
  logic [7:0]  row_stride;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [23:0] exp_q[$];
  logic [23:0] exp_w;

  matrix_result_writer #(.DW(16), .AW(8)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .start      (start),
    .base       (base),
    .rows       (rows),
    .cols       (cols),
    .row_stride (row_stride),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every observed write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_write got addr=%h data=%h, no write expected", mem_addr, mem_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== exp_w) begin
          tests_failed++;
          $display("[TB] FAIL write_pair got addr=%h data=%h, expected addr=%h data=%h",
                   mem_addr, mem_wdata, exp_w[23:16], exp_w[15:0]);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base = '0; rows = '0; cols = '0;
    row_stride = '0; in_valid = 1'b0; in_data = '0;
    #2;
    tests_run++;
    if ({in_ready, mem_we, busy, done, mem_addr, mem_wdata} !== 28'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs got rdy=%b we=%b busy=%b done=%b addr=%h data=%h, expected all 0",
               in_ready, mem_we, busy, done, mem_addr, mem_wdata);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Called at #1 after a clock edge with the DUT idle; returns in the same phase, DUT idle.
  task automatic send_tile(input logic [7:0] b, input logic [7:0] r, input logic [7:0] c,
                           input logic [7:0] s, input bit gaps, input bit poke_start);
    int n;
    logic [7:0] last_addr;
    n = int'(r) * int'(c);
    last_addr = '0;
    for (int i = 0; i < int'(r); i++) begin
      for (int j = 0; j < int'(c); j++) begin
        last_addr = 8'(int'(b) + i * int'(s) + j);
        exp_q.push_back({last_addr, 16'(i * int'(c) + j + 1)});
      end
    end

    tests_run++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_before_start got rdy=%b busy=%b, expected 0 0", in_ready, busy);
    end

    start = 1'b1; base = b; rows = r; cols = c; row_stride = s;
    @(posedge clk); #1;
    start = 1'b0; base = 8'hA5; rows = 8'h07; cols = 8'h09; row_stride = 8'h33;

    if (n == 0) begin
      tests_run++;
      if (done !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL zero_tile_done got done=%b rdy=%b we=%b, expected 1 0 0", done, in_ready, mem_we);
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        if (gaps && k > 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
          tests_run++;
          if (mem_we !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL gap_we got %b, expected 0", mem_we);
          end
        end
        in_valid = 1'b1;
        in_data  = 16'(k + 1);
        if (poke_start && k == 2) begin
          start = 1'b1;
          base  = 8'h40;
        end
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL write_state elem %0d got rdy=%b busy=%b done=%b, expected 1 1 0",
                   k, in_ready, busy, done);
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
      in_valid = 1'b0;
      tests_run++;
      if (done !== 1'b1 || mem_we !== 1'b1 || mem_addr !== last_addr || in_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL done_with_last got done=%b we=%b addr=%h rdy=%b, expected 1 1 %h 0",
                 done, mem_we, mem_addr, in_ready, last_addr);
      end
    end

    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL back_to_idle got done=%b busy=%b we=%b, expected 0 0 0", done, busy, mem_we);
    end
  endtask

  task automatic test_basic();
    send_tile(8'h10, 8'd2, 8'd3, 8'd4, 1'b0, 1'b0);
  endtask

  task automatic test_bubbles();
    send_tile(8'h10, 8'd2, 8'd3, 8'd4, 1'b1, 1'b0);
  endtask

  task automatic test_zero_size();
    send_tile(8'h10, 8'd0, 8'd5, 8'd4, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_ignored_start();
    send_tile(8'hFE, 8'd1, 8'd4, 8'd1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_tile();
    // Third write is registered but cut off by reset before it is observed.
    exp_q.push_back({8'h10, 16'd1});
    exp_q.push_back({8'h11, 16'd2});
    start = 1'b1; base = 8'h10; rows = 8'd2; cols = 8'd3; row_stride = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(k + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({in_ready, mem_we, busy, done, mem_addr, mem_wdata} !== 28'h0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_outputs got rdy=%b we=%b busy=%b done=%b addr=%h data=%h, expected all 0",
               in_ready, mem_we, busy, done, mem_addr, mem_wdata);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      tests_run++;
      if (done !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL mid_reset_done got %b, expected 0", done);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_tile(8'h20, 8'd1, 8'd2, 8'd1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    send_tile(8'h50, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0);
    send_tile(8'h30, 8'd1, 8'd1, 8'd0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_zero_size();
    test_wrap_ignored_start();
    test_reset_mid_tile();
    test_back_to_back();
    @(posedge clk); #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL writes_outstanding got %0d left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
